// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory with programmable wait states.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed A-over-B priority.
module dmem_arbiter #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_gnt_o,
  output logic              a_done_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_gnt_o,
  output logic              b_done_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam logic [2:0] WaitInit = 3'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              win_b_q;
  logic              we_q;
  logic              a_gnt_q, b_gnt_q, a_done_q, b_done_q;
  logic              mem_read_q, mem_write_q, busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, a_rdata_q, b_rdata_q;

  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic last_b_q;

  // On a tie, serve the port that did not win last time.
  always_comb pick_b = b_req_i && (!a_req_i || !last_b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
    end else if (state_q == StIdle && (a_req_i || b_req_i)) begin
      last_b_q <= pick_b;
    end
  end
`else
  always_comb pick_b = !a_req_i;
`endif

  always_comb begin
    sel_we    = pick_b ? b_we_i    : a_we_i;
    sel_addr  = pick_b ? b_addr_i  : a_addr_i;
    sel_wdata = pick_b ? b_wdata_i : a_wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      win_b_q     <= 1'b0;
      we_q        <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (a_req_i || b_req_i) begin
            state_q     <= StAccess;
            win_b_q     <= pick_b;
            we_q        <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            cnt_q       <= WaitInit;
            a_gnt_q     <= !pick_b;
            b_gnt_q     <= pick_b;
            mem_read_q  <= !sel_we;
            mem_write_q <= sel_we && (WaitInit == 3'd0);
            busy_q      <= 1'b1;
          end
        end
        StAccess: begin
          if (cnt_q == 3'd0) begin
            state_q  <= StDone;
            a_done_q <= !win_b_q;
            b_done_q <= win_b_q;
            if (!we_q) begin
              if (win_b_q) b_rdata_q <= mem_rdata_i;
              else         a_rdata_q <= mem_rdata_i;
            end
          end else begin
            cnt_q       <= cnt_q - 3'd1;
            mem_read_q  <= !we_q;
            // Single write strobe, placed in the last ACCESS cycle.
            mem_write_q <= we_q && (cnt_q == 3'd1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    a_gnt_o     = a_gnt_q;
    b_gnt_o     = b_gnt_q;
    a_done_o    = a_done_q;
    b_done_o    = b_done_q;
    a_rdata_o   = a_rdata_q;
    b_rdata_o   = b_rdata_q;
    mem_read_o  = mem_read_q;
    // Reset landing on the strobe cycle must still suppress the memory write.
    mem_write_o = mem_write_q && !rst;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    busy_o      = busy_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: WAIT_STATES=1 main instance plus a
// WAIT_STATES=0 instance for back-to-back throughput; both share one behavioural memory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_init;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, a_done, b_gnt, b_done;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_read, mem_write, busy;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        a1_req, b1_req;
  logic [5:0]  a1_addr;
  logic        a1_gnt, a1_done, b1_gnt, b1_done;
  logic [31:0] a1_rdata, b1_rdata;
  logic        mem1_read, mem1_write, busy1;
  logic [5:0]  mem1_addr;
  logic [31:0] mem1_wdata, mem1_rdata;

  logic [31:0] mem [16];

  assign mem_rdata  = mem[mem_addr[5:2]];
  assign mem1_rdata = mem[mem1_addr[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'd9;
    end else if (mem_write) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_done_o(a_done), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_done_o(b_done), .b_rdata_o(b_rdata),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst(rst),
    .a_req_i(a1_req), .a_we_i(1'b0), .a_addr_i(a1_addr), .a_wdata_i(32'h0),
    .a_gnt_o(a1_gnt), .a_done_o(a1_done), .a_rdata_o(a1_rdata),
    .b_req_i(b1_req), .b_we_i(1'b0), .b_addr_i(6'd0), .b_wdata_i(32'h0),
    .b_gnt_o(b1_gnt), .b_done_o(b1_done), .b_rdata_o(b1_rdata),
    .mem_read_o(mem1_read), .mem_write_o(mem1_write), .mem_addr_o(mem1_addr),
    .mem_wdata_o(mem1_wdata), .mem_rdata_i(mem1_rdata), .busy_o(busy1)
  );

  int checks_passed = 0;
  int checks_total  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on port A or B; latencies counted from the request cycle T.
  task automatic txn(input bit pb, input bit we, input logic [5:0] addr,
                     input logic [31:0] wd, output int g, output int d,
                     output int nrd, output int nwr);
    g = -1; d = -1; nrd = 0; nwr = 0;
    if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    for (int k = 1; k <= 20; k++) begin
      step();
      if ((pb && b_gnt) || (!pb && a_gnt)) g = k;
      if (mem_read)  nrd++;
      if (mem_write) nwr++;
      if ((pb && b_done) || (!pb && a_done)) begin
        d = k;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    step();
  endtask

  // Simultaneous A/B reads; order[i] = 1 when the i-th grant went to B.
  task automatic dual(input bit a_again, output logic [1:0] order, output int ng);
    bit a_redone = 1'b0;
    order = 2'b11;
    ng = 0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd8;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd4;
    for (int k = 0; k < 40; k++) begin
      step();
      if (a_gnt) begin if (ng < 2) order[ng] = 1'b0; ng++; end
      if (b_gnt) begin if (ng < 2) order[ng] = 1'b1; ng++; end
      if (ng >= 2 && !a_gnt && !b_gnt && (a_done || b_done)) break;
      if (a_done) begin
        if (a_again && !a_redone) a_redone = 1'b1;
        else a_req = 1'b0;
      end
      if (b_done) b_req = 1'b0;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    step();
  endtask

  int g, d, nrd, nwr, ng, nd;
  int dc [4];
  logic [1:0] order;

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    a1_req = 1'b0; a1_addr = '0; b1_req = 1'b0;
    step();
    step();
    check_eq("rst_gnt_done", 32'({a_gnt, a_done, b_gnt, b_done}), 32'h0);
    check_eq("rst_a_rdata", a_rdata, 32'h0);
    check_eq("rst_b_rdata", b_rdata, 32'h0);
    check_eq("rst_mem_ctl", 32'({mem_read, mem_write}), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_busy", 32'({busy, busy1}), 32'h0);
    rst = 1'b0; mem_init = 1'b0;
    step();
    check_eq("idle_busy", 32'(busy), 32'h0);
    check_eq("idle_mem_write", 32'(mem_write), 32'h0);

    // A write then read back, WAIT_STATES=1
    txn(1'b0, 1'b1, 6'd8, 32'hDEADBEEF, g, d, nrd, nwr);
    check_eq("wr_gnt_lat", g, 1);
    check_eq("wr_done_lat", d, 3);
    check_eq("wr_strobes", nwr, 1);
    check_eq("wr_reads", nrd, 0);
    check_eq("wr_mem", mem[2], 32'hDEADBEEF);
    check_eq("wr_a_rdata", a_rdata, 32'h0);
    txn(1'b0, 1'b0, 6'd8, 32'h0, g, d, nrd, nwr);
    check_eq("rd_gnt_lat", g, 1);
    check_eq("rd_done_lat", d, 3);
    check_eq("rd_read_cycles", nrd, 2);
    check_eq("rd_writes", nwr, 0);
    check_eq("rd_a_rdata", a_rdata, 32'hDEADBEEF);

    // B read of preloaded word 1
    txn(1'b1, 1'b0, 6'd4, 32'h0, g, d, nrd, nwr);
    check_eq("b_gnt_lat", g, 1);
    check_eq("b_done_lat", d, 3);
    check_eq("b_rdata", b_rdata, 32'd9);
    check_eq("b_a_rdata_kept", a_rdata, 32'hDEADBEEF);

    // Simultaneous requests
    dual(1'b0, order, ng);
    check_eq("tie_grants", ng, 2);
    check_eq("tie_order", 32'(order), 32'h2);
    dual(1'b1, order, ng);
    check_eq("tie_again_grants", ng, 2);
`ifdef DMEM_ARB_RR_EN
    check_eq("tie_again_order", 32'(order), 32'h2);
`else
    check_eq("tie_again_order", 32'(order), 32'h0);
`endif
    check_eq("tie_a_rdata", a_rdata, 32'hDEADBEEF);
    check_eq("tie_b_rdata", b_rdata, 32'd9);

    // Reset during the final ACCESS cycle of an A write
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd12; a_wdata = 32'h12345678;
    step();
    check_eq("rw_gnt", 32'(a_gnt), 32'h1);
    a_req = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check_eq("rw_no_strobe", 32'(mem_write), 32'h0);
    step();
    rst = 1'b0;
    check_eq("rw_busy", 32'(busy), 32'h0);
    check_eq("rw_done", 32'(a_done), 32'h0);
    step();
    check_eq("rw_done_later", 32'({a_done, busy, mem_write}), 32'h0);
    check_eq("rw_mem", mem[3], 32'h0);

    // WAIT_STATES=0, back-to-back A reads with req held
    nd = 0; nrd = 0;
    a1_req = 1'b1; a1_addr = 6'd8;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (mem1_read) nrd++;
      if (a1_done && nd < 4) begin dc[nd] = k; nd++; end
    end
    a1_req = 1'b0;
    check_eq("ws0_dones", nd, 4);
    check_eq("ws0_first_done", (nd > 0) ? dc[0] : -1, 2);
    check_eq("ws0_period1", (nd > 1) ? dc[1] - dc[0] : -1, 3);
    check_eq("ws0_period2", (nd > 2) ? dc[2] - dc[1] : -1, 3);
    check_eq("ws0_read_cycles", nrd, 4);
    check_eq("ws0_rdata", a1_rdata, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
